// File: rtl/conta_pkg.sv
// Shared types and default constants for the count input conditioner.
package conta_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } conta_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/count_input_conditioner.sv
// Debounces a step button into single-cycle count enables with a qualified direction.
// Optional auto-repeat while the button is held is enabled by defining AUTOREPEAT_EN.
module count_input_conditioner
  import conta_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  input  logic dir_raw,
  output logic step_pulse,
  output logic step_dir,
  output logic btn_level
);

  localparam int DB_W = max_int($clog2(DEBOUNCE_CYCLES), 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_MAX  = '1;

  logic btn_s, dir_s;

  sync_2ff u_sync_btn (.clk(clk), .rst_n(rst_n), .d(btn_raw), .q(btn_s));
  sync_2ff u_sync_dir (.clk(clk), .rst_n(rst_n), .d(dir_raw), .q(dir_s));

  conta_state_e    state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            step_pulse_q, step_pulse_d;
  logic            step_dir_q, step_dir_d;

`ifdef AUTOREPEAT_EN
  localparam int RPT_W = max_int($clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)), 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_MAX = '1;

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;
`endif

  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    step_pulse_d = 1'b0;
    step_dir_d   = step_dir_q;
`ifdef AUTOREPEAT_EN
    rpt_cnt_d    = rpt_cnt_q;
    rpt_phase_d  = rpt_phase_q;
`endif
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d  = PRESS_WAIT;
            db_cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_d = IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_d      = HELD;
            db_cnt_d     = '0;
            step_pulse_d = 1'b1;
            step_dir_d   = dir_s;
          end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_d     = RELEASE_WAIT;
            db_cnt_d    = '0;
`ifdef AUTOREPEAT_EN
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b0;
          end else if (rpt_cnt_q == (rpt_phase_q ? RP_LAST : RD_LAST)) begin
            // First repeat waits the long delay, later ones use the shorter period.
            rpt_cnt_d    = '0;
            rpt_phase_d  = 1'b1;
            step_pulse_d = 1'b1;
            step_dir_d   = dir_s;
          end else if (rpt_cnt_q != RPT_MAX) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_d = HELD;
          end else if (db_cnt_q == DB_LAST) begin
            state_d  = IDLE;
            db_cnt_d = '0;
          end else if (db_cnt_q != DB_MAX) begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b1;
`ifdef AUTOREPEAT_EN
      rpt_cnt_q    <= '0;
      rpt_phase_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      step_pulse_q <= step_pulse_d;
      step_dir_q   <= step_dir_d;
`ifdef AUTOREPEAT_EN
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_phase_q  <= rpt_phase_d;
`endif
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign btn_level  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule
